// File: rtl/counter_pkg.sv
// Shared types and helpers for the up/down counter family.
// The state encoding is fixed so cascaded blocks and debug tooling agree on it.
package counter_pkg;

  typedef enum logic {
    COUNT = 1'b0,
    DONE  = 1'b1
  } state_e;

  localparam int WRAP_CNT_W = 8;

  // Clamp a requested load value to the top of the count range.
  function automatic logic [31:0] clamp_load(input logic [31:0] val, input logic [31:0] top);
    return (val > top) ? top : val;
  endfunction

endpackage

// File: rtl/mod_n_up_counter.sv
// Modulo-N up counter with parallel load, one-shot DONE state and wrap pulse.
// Optional saturating wrap counter output enabled by the WRAP_COUNT_EN macro.
module mod_n_up_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             one_shot,
  output logic [WIDTH-1:0] Cout,
  output logic             tc,
  output logic             wrap,
  output logic             done
`ifdef WRAP_COUNT_EN
  ,
  output logic [WRAP_CNT_W-1:0] wrap_cnt
`endif
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

  generate
    if (longint'(MODULUS) < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
      $error("mod_n_up_counter: MODULUS must lie in 2..2**WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] cnt_reg;
  state_e           state_reg;
  logic             wrap_reg;
  logic             done_reg;

  // Combinational so the next stage can use it directly as its enable.
  assign tc = (cnt_reg == TOP) && en && (state_reg == COUNT);

  always_ff @(posedge clk) begin
    if (!clear) begin
      cnt_reg   <= '0;
      state_reg <= COUNT;
      wrap_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else if (load) begin
      cnt_reg   <= WIDTH'(clamp_load(32'(load_val), 32'(MODULUS - 1)));
      state_reg <= COUNT;
      wrap_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else if (state_reg == COUNT && en) begin
      if (cnt_reg == TOP) begin
        if (one_shot) begin
          state_reg <= DONE;
          done_reg  <= 1'b1;
          wrap_reg  <= 1'b0;
        end else begin
          cnt_reg  <= '0;
          wrap_reg <= 1'b1;
        end
      end else begin
        cnt_reg  <= cnt_reg + 1'b1;
        wrap_reg <= 1'b0;
      end
    end else begin
      wrap_reg <= 1'b0;
    end
  end

  assign Cout = cnt_reg;
  assign wrap = wrap_reg;
  assign done = done_reg;

`ifdef WRAP_COUNT_EN
  logic                  wrap_evt;
  logic [WRAP_CNT_W-1:0] wrap_cnt_reg;

  assign wrap_evt = clear && !load && tc && !one_shot;

  always_ff @(posedge clk) begin
    if (!clear) begin
      wrap_cnt_reg <= '0;
    end else if (wrap_evt && (wrap_cnt_reg != {WRAP_CNT_W{1'b1}})) begin
      wrap_cnt_reg <= wrap_cnt_reg + 1'b1;
    end
  end

  assign wrap_cnt = wrap_cnt_reg;
`endif

endmodule
